// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, serialized data, optional parity and stop bits
// around an external LSB-first serializer, which it enables only while data bits are on the line.
//
// state  | meaning
// IDLE   | line idle (1); waiting for Data_Valid
// START  | start bit (0) for one cycle
// DATA   | serializer enabled, TX_OUT follows ser_out until ser_done
// PARITY | latched parity bit for one cycle
// STOP   | stop bit (1) for one cycle, then back to IDLE
module uart_tx_frame_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             ser_out,
    input  logic             ser_done,
    output logic             ser_en,
    output logic             Busy,
    output logic             TX_OUT
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;
    logic   par_bit;
    logic   par_en;
    logic   accept;

    assign accept = (state == IDLE) && Data_Valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame settings are captured on acceptance so mid-frame input changes cannot leak in.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit <= 1'b0;
            par_en  <= 1'b0;
        end else if (accept) begin
            par_bit <= (^P_DATA) ^ PAR_TYP;
            par_en  <= PAR_EN;
        end
    end

    always_comb begin
        state_next = state;
        TX_OUT     = 1'b1;
        Busy       = 1'b0;
        ser_en     = 1'b0;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    state_next = START;
                end
            end
            START: begin
                TX_OUT     = 1'b0;
                Busy       = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                TX_OUT = ser_out;
                Busy   = 1'b1;
                ser_en = 1'b1;
                if (ser_done) begin
                    state_next = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                TX_OUT     = par_bit;
                Busy       = 1'b1;
                state_next = STOP;
            end
            STOP: begin
                Busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: a behavioural serializer plus a per-frame expected-bit list
// built from the UART framing rules, with directed and randomized frames and reset aborts.
module tb_uart_tx_frame_ctrl;
    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         ser_out;
    logic         ser_done;
    logic         ser_en;
    logic         Busy;
    logic         TX_OUT;

    int vec  = 0;
    int miss = 0;

    uart_tx_frame_ctrl #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_out    (ser_out),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .Busy       (Busy),
        .TX_OUT     (TX_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer stand-in: loads the word while the line is not busy, shifts LSB first while enabled.
    logic [W-1:0] ser_word;
    logic [3:0]   ser_cnt;
    logic         spur;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ser_word <= '0;
            ser_cnt  <= '0;
        end else begin
            if (!Busy) ser_word <= P_DATA;
            if (ser_en) ser_cnt <= ser_cnt + 4'd1;
            else        ser_cnt <= '0;
        end
    end

    assign ser_out  = ser_word[ser_cnt[2:0]];
    assign ser_done = (ser_en && ser_cnt == 4'(W - 1)) || (!ser_en && spur);

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        vec++;
        assert (got === exp)
        else begin
            miss++;
            $error("FAIL %s {TX_OUT,Busy,ser_en} got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Expected frame: start 0, data LSB first, optional parity, stop 1; each entry is {TX_OUT,Busy,ser_en}.
    task automatic frame(input logic [W-1:0] d, input logic pe, input logic pt,
                         input bit hold, input int rst_at);
        logic [2:0] exp[$];
        exp.push_back(3'b010);
        for (int i = 0; i < W; i++) exp.push_back({d[i], 1'b1, 1'b1});
        if (pe) exp.push_back({(^d) ^ pt, 1'b1, 1'b0});
        exp.push_back(3'b110);

        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        for (int k = 0; k < exp.size(); k++) begin
            step();
            chk($sformatf("frame_%02h_c%0d", d, k), {TX_OUT, Busy, ser_en}, exp[k]);
            Data_Valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
            P_DATA     = W'($urandom);
            PAR_EN     = 1'($urandom_range(0, 1));
            PAR_TYP    = 1'($urandom_range(0, 1));
            spur       = 1'($urandom_range(0, 1));
            if (k == rst_at) begin
                #1 RST = 1'b0;
                #1 chk($sformatf("rst_async_%02h_c%0d", d, k), {TX_OUT, Busy, ser_en}, 3'b100);
                step();
                chk("rst_held", {TX_OUT, Busy, ser_en}, 3'b100);
                RST        = 1'b1;
                Data_Valid = 1'b0;
                return;
            end
        end
        if (!hold) Data_Valid = 1'b0;
        step();
        chk($sformatf("idle_after_%02h", d), {TX_OUT, Busy, ser_en}, 3'b100);
    endtask

    initial begin
        RST        = 1'b0;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        spur       = 1'b0;
        #1 chk("reset_state", {TX_OUT, Busy, ser_en}, 3'b100);
        Data_Valid = 1'b1;
        step();
        chk("reset_ignores_dv", {TX_OUT, Busy, ser_en}, 3'b100);
        Data_Valid = 1'b0;
        RST        = 1'b1;
        spur       = 1'b1;
        step();
        chk("idle_spurious_done", {TX_OUT, Busy, ser_en}, 3'b100);

        frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        frame(8'h01, 1'b1, 1'b1, 1'b0, -1);
        frame(8'h03, 1'b1, 1'b1, 1'b0, -1);
        frame(8'hFF, 1'b0, 1'b0, 1'b0, -1);
        frame(8'h0F, 1'b1, 1'b0, 1'b1, -1);
        frame(8'hF0, 1'b1, 1'b0, 1'b0, -1);
        frame(8'hA5, 1'b1, 1'b0, 1'b0, 4);
        frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] d;
            logic         pe;
            logic         pt;
            int           ra;
            d  = W'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            frame(d, pe, pt, 1'($urandom_range(0, 1)), ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, data word width; SHALL be a power of two >= 2 so the serializer's ser_done marks bit WIDTH-1.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 P_DATA  input  WIDTH  parallel word, same bus that feeds the serializer DATA input; used here only for parity.
REQ-005 Data_Valid  input  1  frame request; accepted only while Busy=0.
REQ-006 PAR_EN  input  1  1 = insert parity bit, 0 = no parity bit.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 ser_out  input  1  current data bit from the serializer (LSB first).
REQ-009 ser_done  input  1  serializer flag, high during last data bit.
REQ-010 ser_en  output  1  serializer shift/count enable (drives its Enable).
REQ-011 Busy  output  1  frame in progress (drives serializer Busy).
REQ-012 TX_OUT  output  1  serial line; idle level 1.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; the state register is the only FSM storage.
REQ-014 IDLE: TX_OUT=1, Busy=0, ser_en=0; Data_Valid=1 at a rising edge -> START.
REQ-015 On acceptance the block SHALL latch par_bit = (XOR-reduce P_DATA) XOR PAR_TYP and latch PAR_EN; later changes to P_DATA/PAR_EN/PAR_TYP do not affect the frame.
REQ-016 START: TX_OUT=0, Busy=1, ser_en=0; one cycle -> DATA.
REQ-017 DATA: TX_OUT=ser_out, Busy=1, ser_en=1; stays WIDTH cycles; ser_done=1 -> PARITY if latched PAR_EN=1, else STOP.
REQ-018 PARITY: TX_OUT=par_bit, Busy=1, ser_en=0; one cycle -> STOP.
REQ-019 STOP: TX_OUT=1, Busy=1, ser_en=0; one cycle -> IDLE unconditionally.
REQ-020 Outputs SHALL be decoded combinationally from the state register (plus ser_out in DATA, par_bit in PARITY); no combinational path from Data_Valid to any output.
REQ-021 Frame length: WIDTH+3 cycles with parity, WIDTH+2 without; Busy high for exactly that many cycles.
REQ-022 Data_Valid while Busy=1 SHALL be ignored (no queuing); held-high Data_Valid yields one IDLE cycle (TX_OUT=1) between frames.
REQ-023 ser_done outside DATA SHALL be ignored.
REQ-024 ser_en SHALL be low in every non-DATA state so the serializer counter clears between frames.

Reset
REQ-025 RST=0 SHALL immediately force state IDLE, par_bit=0, latched PAR_EN=0: TX_OUT=1, Busy=0, ser_en=0, independent of CLK.
REQ-026 Reset mid-frame SHALL abort the frame with no further bits; the first Data_Valid after release starts a complete new frame.

Verification
REQ-027 Reset: RST=0 at any state -> same cycle TX_OUT=1, Busy=0, ser_en=0.
REQ-028 WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,0,1; Busy high 11 cycles; ser_en high cycles 2-9.
REQ-029 P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity cycle TX_OUT=0; P_DATA=0x03, PAR_TYP=1 -> parity TX_OUT=1.
REQ-030 P_DATA=0xFF, PAR_EN=0 -> 0, eight 1s, 1; Busy high 10 cycles; PARITY never entered.
REQ-031 Data_Valid held high, P_DATA 0x0F then 0xF0 -> two back-to-back frames with exactly one TX_OUT=1 IDLE cycle between; P_DATA change during frame 1 does not alter its parity bit.
REQ-032 RST pulsed low during 4th DATA cycle -> TX_OUT=1, Busy=0 immediately; after release, Data_Valid with 0xA5 reproduces the REQ-028 sequence.
